trap_shaper_cfg: RTL and testbench

- Runtime-configurable, valid-qualified trapezoidal pulse-shaping filter for one ADC stream.
- Successor to the fixed-coefficient shaper: delay depth, gap, pole-zero and gain coefficients are loadable registers rather than package constants.
- Adds input-valid handling, a warm-up state machine, a flush-on-reconfigure rule and a saturating output.
- Sits between the ADC capture block and the peak/energy extraction logic.

---
 rtl/trap_shaper_cfg.sv | 238 +++++++++++++++++++++++
 tb/tb_trap_shaper_cfg.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_shaper_cfg.sv
// Runtime-configurable trapezoidal shaper: valid-tagged 7-register pipeline, warm-up FSM,
// flush on cfg_load, saturating output. Define TRAP_SHAPER_PEAK_EN to add the peak detector.
module trap_shaper_cfg #(
  parameter int ADC_W     = 14,
  parameter int OUT_W     = 16,
  parameter int ACC_W     = 40,
  parameter int COEF_W    = 12,
  parameter int MAX_DEPTH = 64,
  parameter int SHIFT     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [ADC_W-1:0]        in_data,
  input  logic                    cfg_load,
  input  logic [6:0]              cfg_k,
  input  logic [6:0]              cfg_l,
  input  logic [COEF_W-1:0]       cfg_kc,
  input  logic [COEF_W-1:0]       cfg_m1,
  input  logic [COEF_W-1:0]       cfg_m2,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_primed,
  output logic                    out_sat,
  output logic                    cfg_err
`ifdef TRAP_SHAPER_PEAK_EN
  ,
  input  logic signed [OUT_W-1:0] cfg_thr,
  output logic                    peak_valid,
  output logic signed [OUT_W-1:0] peak_data
`endif
);
  localparam int PROD_W = COEF_W + ADC_W + 2;
  localparam int FULL_W = ACC_W + COEF_W + 1;
  localparam int DIFF_W = ADC_W + 1;
  localparam int IDX_W  = $clog2(MAX_DEPTH);
  localparam int STAGES = 6;
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  // Coefficient product, kept at PROD_W bits and sign-extended by the caller.
  function automatic logic signed [PROD_W-1:0] coef_mul(input logic [COEF_W-1:0] c,
                                                        input logic signed [ACC_W-1:0] v);
    logic signed [FULL_W-1:0] a, b, full;
    a    = FULL_W'($signed({1'b0, c}));
    b    = FULL_W'(v);
    full = a * b;
    return full[PROD_W-1:0];
  endfunction

  logic [6:0]        k_r, l_r, k_clamp, l_clamp, need, cnt, cnt_nxt;
  logic [COEF_W-1:0] kc_r, m1_r, m2_r;
  logic              clamp_err;
  state_t            state, state_nxt;

  logic [ADC_W-1:0]         x_r;
  logic [ADC_W-1:0]         dl   [MAX_DEPTH-1];
  logic [ADC_W-1:0]         hist [MAX_DEPTH];
  logic [IDX_W-1:0]         k_idx, l_idx, l_idx1;
  logic signed [DIFF_W-1:0] d_b, e_b, d_c;
  logic signed [PROD_W-1:0] ke_c, m1p_e, m2p_e;
  logic signed [ACC_W-1:0]  p, q, s, q_sum, s_sh;
  logic [STAGES-1:0]        vld, prim;
  logic signed [OUT_W-1:0]  y_nxt;
  logic                     y_sat;

  // NOTE: defaults are assigned first so no path leaves a variable unassigned (no latch).
  always_comb begin
    k_clamp   = cfg_k;
    l_clamp   = cfg_l;
    clamp_err = 1'b0;
    if (cfg_k == 7'd0) begin
      k_clamp   = 7'd1;
      clamp_err = 1'b1;
    end else if (int'(cfg_k) > MAX_DEPTH - 1) begin
      k_clamp   = 7'(MAX_DEPTH - 1);
      clamp_err = 1'b1;
    end
    if (int'(cfg_l) + 1 > MAX_DEPTH - 1) begin
      l_clamp   = 7'(MAX_DEPTH - 2);
      clamp_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_r     <= 7'd1;
      l_r     <= 7'd0;
      kc_r    <= '0;
      m1_r    <= '0;
      m2_r    <= '0;
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      k_r     <= k_clamp;
      l_r     <= l_clamp;
      kc_r    <= cfg_kc;
      m1_r    <= cfg_m1;
      m2_r    <= cfg_m2;
      cfg_err <= clamp_err;
    end
  end

  // Warm-up: count accepted samples until the deepest tap holds real history.
  assign need = (k_r > l_r + 7'd1) ? k_r : l_r + 7'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (cfg_load) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (in_valid) begin
      case (state)
        IDLE: begin
          cnt_nxt   = 7'd1;
          state_nxt = (7'd1 >= need) ? RUN : FILL;
        end
        FILL: begin
          cnt_nxt = cnt + 7'd1;
          if (cnt + 7'd1 >= need) state_nxt = RUN;
        end
        default: ;
      endcase
    end
  end

  // hist[i] is x[n-i] for the sample currently in stage A.
  always_comb begin
    hist[0] = x_r;
    for (int i = 1; i < MAX_DEPTH; i++) hist[i] = dl[i-1];
  end

  assign k_idx  = k_r[IDX_W-1:0];
  assign l_idx  = l_r[IDX_W-1:0];
  assign l_idx1 = l_idx + IDX_W'(1);
  assign q_sum  = q + ACC_W'(m2p_e);
  assign s_sh   = s >>> SHIFT;

  always_comb begin
    y_nxt = s_sh[OUT_W-1:0];
    y_sat = 1'b0;
    if (s_sh > Y_MAX) begin
      y_nxt = Y_MAX[OUT_W-1:0];
      y_sat = 1'b1;
    end else if (s_sh < Y_MIN) begin
      y_nxt = Y_MIN[OUT_W-1:0];
      y_sat = 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every stage reads its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the delay line is reset deliberately: FILL-phase outputs must see zero history.
      for (int i = 0; i < MAX_DEPTH - 1; i++) dl[i] <= '0;
      x_r <= '0;  d_b <= '0;  e_b <= '0;  d_c <= '0;  ke_c <= '0;
      m1p_e <= '0;  m2p_e <= '0;  p <= '0;  q <= '0;  s <= '0;
      vld <= '0;  prim <= '0;
      out_valid <= 1'b0;  out_data <= '0;  out_primed <= 1'b0;  out_sat <= 1'b0;
    end else if (cfg_load) begin
      for (int i = 0; i < MAX_DEPTH - 1; i++) dl[i] <= '0;
      p <= '0;  q <= '0;  s <= '0;
      vld <= '0;  prim <= '0;
      out_valid <= 1'b0;  out_primed <= 1'b0;  out_sat <= 1'b0;
    end else begin
      vld  <= {vld[STAGES-2:0], in_valid};
      prim <= {prim[STAGES-2:0], in_valid && (state_nxt == RUN)};
      if (in_valid) x_r <= in_data;
      if (vld[0]) begin
        d_b   <= $signed({1'b0, hist[0]}) - $signed({1'b0, hist[k_idx]});
        e_b   <= $signed({1'b0, hist[l_idx]}) - $signed({1'b0, hist[l_idx1]});
        dl[0] <= x_r;
        for (int i = 1; i < MAX_DEPTH - 1; i++) dl[i] <= dl[i-1];
      end
      if (vld[1]) begin
        d_c  <= d_b;
        ke_c <= coef_mul(kc_r, ACC_W'(e_b));
      end
      if (vld[2]) p <= p + ACC_W'(d_c) - ACC_W'(ke_c);
      if (vld[3]) begin
        m1p_e <= coef_mul(m1_r, p);
        m2p_e <= coef_mul(m2_r, p);
      end
      if (vld[4]) begin
        q <= q_sum;
        s <= s + q_sum + ACC_W'(m1p_e);
      end
      out_valid <= vld[5];
      if (vld[5]) begin
        out_data <= y_nxt;
        out_sat  <= y_sat;
        if (prim[5]) out_primed <= 1'b1;
      end
    end
  end

`ifdef TRAP_SHAPER_PEAK_EN
  logic signed [OUT_W-1:0] thr_r, pk_max;
  logic                    pk_open;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thr_r      <= '0;
      pk_max     <= '0;
      pk_open    <= 1'b0;
      peak_valid <= 1'b0;
      peak_data  <= '0;
    end else begin
      peak_valid <= 1'b0;
      if (cfg_load) begin
        thr_r   <= cfg_thr;
        pk_open <= 1'b0;
      end else if (out_valid && out_primed) begin
        if (out_data > thr_r) begin
          if (!pk_open || out_data > pk_max) pk_max <= out_data;
          pk_open <= 1'b1;
        end else if (pk_open) begin
          peak_valid <= 1'b1;
          peak_data  <= pk_max;
          pk_open    <= 1'b0;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_trap_shaper_cfg.sv
// Self-checking bench for trap_shaper_cfg: directed steps plus $urandom traffic, compared
// against an arithmetic model of the shaping equations with a due-cycle scoreboard.
module tb_trap_shaper_cfg;
  localparam int ADC_W  = 14;
  localparam int OUT_W  = 16;
  localparam int ACC_W  = 40;
  localparam int COEF_W = 12;
  localparam int SHIFT  = 4;
  localparam int PROD_W = COEF_W + ADC_W + 2;

  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, cfg_load = 1'b0;
  logic [ADC_W-1:0]  in_data = '0;
  logic [6:0]        cfg_k = 7'd1, cfg_l = 7'd0;
  logic [COEF_W-1:0] cfg_kc = '0, cfg_m1 = '0, cfg_m2 = '0;
  logic              out_valid, out_primed, out_sat, cfg_err;
  logic signed [OUT_W-1:0] out_data;
`ifdef TRAP_SHAPER_PEAK_EN
  logic signed [OUT_W-1:0] cfg_thr = 16'sd50;
  logic                    peak_valid;
  logic signed [OUT_W-1:0] peak_data;
`endif

  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  trap_shaper_cfg dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .cfg_load   (cfg_load),
    .cfg_k      (cfg_k),
    .cfg_l      (cfg_l),
    .cfg_kc     (cfg_kc),
    .cfg_m1     (cfg_m1),
    .cfg_m2     (cfg_m2),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_primed (out_primed),
    .out_sat    (out_sat),
    .cfg_err    (cfg_err)
`ifdef TRAP_SHAPER_PEAK_EN
    ,
    .cfg_thr    (cfg_thr),
    .peak_valid (peak_valid),
    .peak_data  (peak_data)
`endif
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: history of accepted samples since the last load, the three
  // accumulators as plain integers, and a queue of outputs keyed by their due edge.
  typedef struct { longint due; longint y; bit sat; bit prim; } exp_t;
  exp_t   pend[$];
  int     hist_q[$];
  int     mk = 1, ml = 0;
  longint mkc = 0, mm1 = 0, mm2 = 0, mp = 0, mq = 0, ms = 0, cyc = 0;

  function automatic longint sx(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint hx(input int idx);
    return (idx < 0) ? 0 : longint'(hist_q[idx]);
  endfunction

  task automatic model_sample(input int x);
    int     n;
    longint d, e, y;
    exp_t   ex;
    hist_q.push_back(x);
    n  = hist_q.size() - 1;
    d  = hx(n) - hx(n - mk);
    e  = hx(n - ml) - hx(n - ml - 1);
    mp = sx(mp + d - sx(mkc * e, PROD_W), ACC_W);
    mq = sx(mq + sx(mm2 * mp, PROD_W), ACC_W);
    ms = sx(ms + mq + sx(mm1 * mp, PROD_W), ACC_W);
    y  = ms >>> SHIFT;
    ex.sat  = (y > 32767) || (y < -32768);
    ex.y    = (y > 32767) ? 32767 : (y < -32768) ? -32768 : y;
    ex.prim = (n + 1) >= ((mk > ml + 1) ? mk : ml + 1);
    ex.due  = cyc + 6;
    pend.push_back(ex);
  endtask

  task automatic model_load();
    mk  = (cfg_k == 0) ? 1 : (cfg_k > 63) ? 63 : int'(cfg_k);
    ml  = (cfg_l > 62) ? 62 : int'(cfg_l);
    mkc = longint'(cfg_kc);
    mm1 = longint'(cfg_m1);
    mm2 = longint'(cfg_m2);
    mp = 0; mq = 0; ms = 0;
    hist_q.delete();
    pend.delete();
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend.delete(); hist_q.delete();
      mk = 1; ml = 0; mkc = 0; mm1 = 0; mm2 = 0; mp = 0; mq = 0; ms = 0;
    end else begin
      cyc++;
      if (cfg_load) model_load();
      else if (in_valid) model_sample(int'(in_data));
    end
  end

  bit due_now;
  always @(negedge clk) begin
    if (reset) begin
      due_now = (pend.size() > 0) && (pend[0].due == cyc);
      if (out_valid || due_now) begin
        check("out_valid", out_valid, due_now);
        if (out_valid && due_now) begin
          check("out_data", out_data, pend[0].y);
          check("out_sat", out_sat, pend[0].sat);
          check("out_primed", out_primed, pend[0].prim);
        end
        if (due_now) void'(pend.pop_front());
      end
    end
  end

  task automatic step(input bit iv, input int data);
    @(negedge clk);
    cfg_load = 1'b0;
    in_valid = iv;
    in_data  = ADC_W'(data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic load(input int k, input int l, input int kc, input int m1, input int m2,
                      input bit iv);
    @(negedge clk);
    cfg_k = 7'(k); cfg_l = 7'(l);
    cfg_kc = COEF_W'(kc); cfg_m1 = COEF_W'(m1); cfg_m2 = COEF_W'(m2);
    cfg_load = 1'b1;
    in_valid = iv;
    in_data  = 14'd555;
  endtask

  task automatic after_load(input bit exp_err);
    @(negedge clk);
    cfg_load = 1'b0;
    in_valid = 1'b0;
    check("cfg_err", cfg_err, exp_err);
    check("primed_after_load", out_primed, 0);
    check("valid_after_load", out_valid, 0);
  endtask

  initial begin
    int k, l;
    // Reset held with in_valid toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_data  = 14'd1000;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_primed", out_primed, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_cfg_err", cfg_err, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;

    // Default configuration straight out of reset.
    for (int i = 0; i < 8; i++) step(1'b1, 500 + 37 * i);
    idle(8);

    // Step response, continuous then on alternate cycles.
    load(4, 0, 0, 1, 0, 1'b0);
    after_load(1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 100);
    idle(8);
    load(4, 0, 0, 1, 0, 1'b0);
    after_load(1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 100);
      step(1'b0, 0);
    end
    idle(8);

    // Reconfigure with three samples in flight; the load-cycle sample is dropped.
    load(4, 1, 3, 2, 1, 1'b0);
    after_load(1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, int'($urandom_range(0, 2000)));
    idle(3);
    load(3, 0, 0, 1, 0, 1'b1);
    after_load(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 200);
    idle(8);

    // Positive and negative saturation.
    load(1, 0, 0, 1, 0, 1'b0);
    after_load(1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 16383);
    idle(7);
    check("sat_pos_data", out_data, 32767);
    check("sat_pos_flag", out_sat, 1);
    load(1, 0, 2, 1, 0, 1'b0);
    after_load(1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 16383);
    idle(7);
    check("sat_neg_data", out_data, -32768);
    check("sat_neg_flag", out_sat, 1);

    // Range clamps and sticky error.
    load(100, 70, 0, 1, 0, 1'b0);
    after_load(1'b1);
    for (int i = 0; i < 70; i++) step(1'b1, int'($urandom_range(0, 16383)));
    idle(8);
    load(0, 5, 1, 1, 1, 1'b0);
    after_load(1'b1);
    load(5, 3, 0, 1, 0, 1'b0);
    after_load(1'b0);

    // Randomised configurations and traffic; each load lands on live data.
    for (int r = 0; r < 5; r++) begin
      k = int'($urandom_range(0, 70));
      l = int'($urandom_range(0, 70));
      load(k, l, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
           int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
      after_load((k == 0) || (k > 63) || (l > 62));
      for (int i = 0; i < 120; i++)
        step($urandom_range(0, 3) != 0, int'($urandom_range(0, 16383)));
    end

    // Asynchronous reset in the middle of traffic.
    load(100, 2, 5, 7, 3, 1'b0);
    after_load(1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, int'($urandom_range(0, 16383)));
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_primed", out_primed, 0);
    check("midrst_out_sat", out_sat, 0);
    check("midrst_cfg_err", cfg_err, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, int'($urandom_range(0, 16383)));
    idle(10);
    check("drain", pend.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
